serial_add_sequencer: RTL and testbench
=======================================

Name: serial_add_sequencer

Overview:
Bit-serial adder controller that sits directly upstream of the 1-bit full adder stage and also consumes its outputs. It loads two WIDTH-bit operands and feeds them LSB-first to the full adder as A/B, one bit per clock. It registers Cout back into Cin and shifts each Sum bit into a result register. Result and final carry are presented with a done pulse, so a single full adder performs multi-bit addition over WIDTH cycles.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an addition; sampled only when not busy
op_a  input  WIDTH  operand A; captured on accepted start
op_b  input  WIDTH  operand B; captured on accepted start
cin_init  input  1  initial carry-in; captured on accepted start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result; holds last value until the next completion
cout  output  1  final carry-out; holds like sum
fa_a  output  1  to full adder A
fa_b  output  1  to full adder B
fa_cin  output  1  to full adder Cin
fa_sum  input  1  from full adder Sum (combinational from fa_a/fa_b/fa_cin)
fa_cout  input  1  from full adder Cout

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values:
  - busy=0, done=0, sum=0, cout=0.
  - fa_a=fa_b=fa_cin=0.
  - Internal state IDLE; bit counter 0; internal shift/carry registers 0.
- State IDLE:
  - busy=0.
  - fa_a, fa_b and fa_cin are driven 0.
  - If start=1 at a rising edge:
    - a_sh<=op_a, b_sh<=op_b, carry<=cin_init, cnt<=0, state<=RUN.
    - sum_sh is cleared to 0.
- State RUN:
  - busy=1.
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry. These are driven directly from registers, with no combinational path from the inputs.
  - Each rising edge:
    - carry<=fa_cout.
    - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1, with zero fill.
    - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (last bit):
    - sum<={fa_sum, sum_sh[WIDTH-1:1]}, cout<=fa_cout.
    - done<=1, state<=IDLE.
- done:
  - Registered; high for exactly one cycle.
  - Otherwise 0.
- Latency:
  - Start accepted at edge E0.
  - done, sum and cout become valid after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
  - busy is high for exactly WIDTH cycles.
- Back-to-back operation:
  - The state is IDLE during the done cycle, so a start asserted in that cycle is accepted.
  - Throughput is one addition per WIDTH cycles.
  - sum/cout update only at completion; they stay stable through the next operation until its own done.
- start while busy: ignored. Operands, carry and count are unaffected; no queuing.
- start held high continuously: a new operation is accepted on every cycle where state is IDLE.
- Operand changes on op_a/op_b/cin_init during RUN have no effect.
- Arithmetic:
  - {cout,sum} = op_a + op_b + cin_init, modulo 2^(WIDTH+1).
  - Wrap-around of sum is reported through cout only.
- Reset mid-operation:
  - Immediately aborts the addition.
  - All outputs return to reset values, including sum/cout, which are cleared.
  - No done is produced for the aborted addition.
- Counter width: $clog2(WIDTH). No other counter saturation or overflow is possible.

Test Plan:
1. The bench connects a behavioural full adder to the fa_* ports. WIDTH=8, op_a=0x5A, op_b=0x33, cin_init=0, one-cycle start -> busy high 8 cycles; done pulses 8 cycles after acceptance; sum=0x8D, cout=0.
2. op_a=0xFF, op_b=0x01, cin_init=0 -> sum=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin_init=1 -> sum=0xFF, cout=1.
3. Start 0x10+0x20, then pulse start with 0xAA+0x55 at cycle 3 of busy -> second start ignored; done once with sum=0x30, cout=0; no further done.
4. Hold start high with 0x01+0x01, change operands to 0x80+0x80 in the done cycle -> first done sum=0x02, cout=0; next accepted immediately; second done exactly 8 cycles later with sum=0x00, cout=1.
5. Start 0x0F+0x0F, assert rst asynchronously (mid-cycle) at busy cycle 4 -> busy, done, sum, cout and fa_* go to 0 immediately; no done after rst release; a fresh 0x03+0x04 then yields sum=0x07.
6. Randomised check: 200 random op_a/op_b/cin_init at WIDTH=8 and WIDTH=3 -> {cout,sum} matches the reference sum every time; done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first through an external 1-bit full adder.
// Result and carry appear with a one-cycle done pulse WIDTH cycles after start is accepted; start is ignored while busy.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (start) state_d = RUN;
    end else begin
      if (cnt_q == LAST) state_d = IDLE;
    end
  end

  // Datapath: load on accepted start, shift one bit per cycle while running.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_sh_d   = op_a;
        b_sh_d   = op_b;
        carry_d  = cin_init;
        cnt_d    = '0;
        sum_sh_d = '0;
      end
    end else begin
      carry_d  = fa_cout;
      sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        sum_d  = {fa_sum, sum_sh_q[WIDTH-1:1]};
        cout_d = fa_cout;
        done_d = 1'b1;
      end
    end
  end

  // Full-adder feeds come straight from flops so the adder sees no input-port paths.
  always_comb begin
    busy   = (state_q == RUN);
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == RUN) begin
      fa_a   = a_sh_q[0];
      fa_b   = b_sh_q[0];
      fa_cin = carry_q;
    end
    done = done_q;
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer at WIDTH=8 and WIDTH=3, each with a behavioural full adder.
module tb_serial_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       st8 = 1'b0, c8 = 1'b0, busy8, done8, cout8, fa8, fb8, fc8, fs8, fco8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       st3 = 1'b0, c3 = 1'b0, busy3, done3, cout3, fa3, fb3, fc3, fs3, fco3;
  logic [2:0] a3 = '0, b3 = '0, sum3;

  assign {fco8, fs8} = 2'(fa8) + 2'(fb8) + 2'(fc8);
  assign {fco3, fs3} = 2'(fa3) + 2'(fb3) + 2'(fc3);

  serial_add_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .op_a(a8), .op_b(b8), .cin_init(c8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa8), .fa_b(fb8), .fa_cin(fc8), .fa_sum(fs8), .fa_cout(fco8));

  serial_add_sequencer #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(st3), .op_a(a3), .op_b(b3), .cin_init(c3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3),
    .fa_a(fa3), .fa_b(fb3), .fa_cin(fc3), .fa_sum(fs3), .fa_cout(fco3));

  int total = 0;
  int bad = 0;
  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic prev8 = 1'b0, prev3 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (done8) begin
        chk("done8_width", 32'(prev8), 0);
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else chk("sum8", 32'({cout8, sum8}), 32'(q8.pop_front()));
      end
      if (done3) begin
        chk("done3_width", 32'(prev3), 0);
        if (q3.size() == 0) chk("done3_unexpected", 1, 0);
        else chk("sum3", 32'({cout3, sum3}), 32'(q3.pop_front()));
      end
      prev8 = done8;
      prev3 = done3;
    end else begin
      prev8 = 1'b0;
      prev3 = 1'b0;
    end
  end

  task automatic issue(input bit w3, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input bit push);
    if (!w3) begin
      st8 = 1'b1; a8 = a; b8 = b; c8 = c;
      if (push) q8.push_back(9'(a) + 9'(b) + 9'(c));
    end else begin
      st3 = 1'b1; a3 = a[2:0]; b3 = b[2:0]; c3 = c;
      if (push) q3.push_back(4'(a[2:0]) + 4'(b[2:0]) + 4'(c));
    end
    @(posedge clk);
    #1;
    st8 = 1'b0;
    st3 = 1'b0;
  endtask

  task automatic wait_done(input bit w3);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w3 ? done3 : done8) return;
    end
    total++;
    bad++;
    $display("FAIL wait_done: got timeout want done");
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done8) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, n;
    #2;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_sum", 32'({cout8, sum8}), 0);
    chk("rst_fa", 32'({fa8, fb8, fc8}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: latency and busy width
    issue(0, 8'h5A, 8'h33, 0, 1);
    lat = -1;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
      if (busy8) bcnt++;
    end
    chk("t1_latency", 32'(lat), 8);
    chk("t1_busy_cycles", 32'(bcnt), 8);
    chk("t1_busy_low_at_done", 32'(busy8), 0);

    // 2: carry wrap cases
    issue(0, 8'hFF, 8'h01, 0, 1);
    wait_done(0);
    issue(0, 8'hFF, 8'hFF, 1, 1);
    wait_done(0);

    // 3: start while busy is ignored
    issue(0, 8'h10, 8'h20, 0, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    wait_done(0);
    chk("t3_sum_direct", 32'(sum8), 32'h30);
    count_dones(20, n);
    chk("t3_no_extra_done", 32'(n), 0);

    // 4: start held high, operands changed in the done cycle
    st8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
    q8.push_back(9'h002);
    wait_done(0);
    a8 = 8'h80; b8 = 8'h80;
    q8.push_back(9'h100);
    @(posedge clk);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        lat = i;
        break;
      end
    end
    st8 = 1'b0;
    chk("t4_b2b_latency", 32'(lat), 8);
    chk("t4_cout_direct", 32'(cout8), 1);

    // 5: asynchronous reset mid-operation
    issue(0, 8'h0F, 8'h0F, 0, 1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q8.delete();
    #1;
    chk("t5_busy", 32'(busy8), 0);
    chk("t5_done", 32'(done8), 0);
    chk("t5_sum_cout", 32'({cout8, sum8}), 0);
    chk("t5_fa", 32'({fa8, fb8, fc8}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_dones(20, n);
    chk("t5_no_done_after_rst", 32'(n), 0);
    issue(0, 8'h03, 8'h04, 0, 1);
    wait_done(0);
    chk("t5_fresh_sum", 32'(sum8), 32'h07);

    // 6: random operands at both widths
    for (int i = 0; i < 200; i++) begin
      issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1);
      wait_done(0);
    end
    for (int i = 0; i < 200; i++) begin
      issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1);
      wait_done(1);
    end
    @(negedge clk);
    @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
